// File: rtl/aes_sub_shift.sv
// Column-serial AES SubBytes + ShiftRows: four S-boxes, one column per cycle, results scattered to shifted positions.
// Optional inverse cipher support (InvSubBytes + InvShiftRows) is built when AES_INV_CIPHER_EN is defined.
module aes_sub_shift (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0][7:0] in_state,
    input  logic             in_dec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0][7:0] out_state
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       col_reg, col_next;
    logic [15:0][7:0] in_reg, in_next;
    logic [15:0][7:0] out_reg, out_next;
    logic [3:0][7:0]  sub;
    logic [3:0][1:0]  dst_col;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128, which maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = a;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] t;
        t = gf_inv(x);
        return t ^ rotl(t, 1) ^ rotl(t, 2) ^ rotl(t, 3) ^ rotl(t, 4) ^ 8'h63;
    endfunction

`ifdef AES_INV_CIPHER_EN
    logic dec_reg, dec_next;

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction
`else
    logic unused_in_dec;
    assign unused_in_dec = in_dec;
`endif

    // One S-box per row; the destination column undoes/applies the row rotation
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            localparam logic [1:0] ROW = gi;
            logic [7:0] src_byte;
            assign src_byte = in_reg[{col_reg, ROW}];
`ifdef AES_INV_CIPHER_EN
            assign sub[gi]     = dec_reg ? inv_sbox(src_byte) : fwd_sbox(src_byte);
            assign dst_col[gi] = dec_reg ? col_reg + ROW : col_reg - ROW;
`else
            assign sub[gi]     = fwd_sbox(src_byte);
            assign dst_col[gi] = col_reg - ROW;
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            col_reg   <= 2'd0;
            in_reg    <= '0;
            out_reg   <= '0;
`ifdef AES_INV_CIPHER_EN
            dec_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            in_reg    <= in_next;
            out_reg   <= out_next;
`ifdef AES_INV_CIPHER_EN
            dec_reg   <= dec_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        in_next    = in_reg;
`ifdef AES_INV_CIPHER_EN
        dec_next   = dec_reg;
`endif
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    in_next    = in_state;
`ifdef AES_INV_CIPHER_EN
                    dec_next   = in_dec;
`endif
                    col_next   = 2'd0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                col_next = col_reg + 2'd1;
                if (col_reg == 2'd3) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_next = out_reg;
        if (state_reg == BUSY) begin
            for (int r = 0; r < 4; r++) begin
                out_next[{dst_col[r], 2'(r)}] = sub[r];
            end
        end
    end

    assign out_state = out_reg;

endmodule

// File: tb/tb_aes_sub_shift.sv
// Self-checking bench for aes_sub_shift: directed FIPS-197 vectors, random blocks, backpressure, back-to-back, mid-block reset.
module tb_aes_sub_shift;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0][7:0] in_state;
    logic             in_dec;
    logic             out_valid;
    logic             out_ready;
    logic [15:0][7:0] out_state;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int sbox_t  [256];
    int isbox_t [256];

    aes_sub_shift dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_dec    (in_dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // S-box tables from log/antilog over generator 3 plus the bitwise affine equation
    task automatic build_tables;
        int exp_t [256];
        int log_t [256];
        int x;
        int v;
        int b;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x ^ (((x << 1) & 255) ^ (((x & 128) != 0) ? 27 : 0));
        end
        for (int a = 0; a < 256; a++) begin
            v = (a == 0) ? 0 : exp_t[(255 - log_t[a]) % 255];
            b = 0;
            for (int i = 0; i < 8; i++) begin
                b |= (((v >> i) ^ (v >> ((i + 4) % 8)) ^ (v >> ((i + 5) % 8)) ^
                       (v >> ((i + 6) % 8)) ^ (v >> ((i + 7) % 8)) ^ (99 >> i)) & 1) << i;
            end
            sbox_t[a] = b;
        end
        for (int a = 0; a < 256; a++) isbox_t[sbox_t[a]] = a;
    endtask

    // Byte list written left-to-right as byte 0..15
    function automatic logic [127:0] from_spec(input logic [127:0] v);
        logic [15:0][7:0] r;
        for (int k = 0; k < 16; k++) r[k] = v[127 - 8 * k -: 8];
        return r;
    endfunction

    // Gather form: forward row r rotates left by r, inverse rotates right by r
    function automatic logic [127:0] model(input logic [127:0] sv, input logic dec);
        logic [15:0][7:0] s;
        logic [15:0][7:0] o;
        logic             d;
        s = sv;
`ifdef AES_INV_CIPHER_EN
        d = dec;
`else
        d = 1'b0 & dec;
`endif
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (d) o[c * 4 + r] = 8'(isbox_t[s[((c - r + 4) % 4) * 4 + r]]);
                else   o[c * 4 + r] = 8'(sbox_t[s[((c + r) % 4) * 4 + r]]);
            end
        end
        return o;
    endfunction

    task automatic accept_block(input logic [127:0] data, input logic dec);
        chk("in_ready_before_accept", 128'(in_ready), 128'(1'b1));
        in_state = data;
        in_dec   = dec;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("out_valid_after_accept", 128'(out_valid), 128'(1'b0));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick;
            n++;
        end
        chk(tag, 128'(n), 128'(4));
    endtask

    task automatic run_block(input string tag, input logic [127:0] data, input logic dec);
        accept_block(data, dec);
        wait_done({tag, "_latency"});
        chk(tag, out_state, model(data, dec));
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, "_idle_after"}, 128'({in_ready, out_valid}), 128'(2'b10));
    endtask

    logic [127:0] fips_in, fips_out, rnd, pend, snap, blk_a, blk_b;
    logic [127:0] got [2];
    int           acc_t [2];
    int           acc, outs;

    initial begin
        build_tables();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_dec    = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        tick;
        tick;
        chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
        chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
        chk("reset_out_state", out_state, 128'd0);
        rst_n = 1'b1;
        tick;

        fips_in  = from_spec(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        fips_out = from_spec(128'hd4bf5d30e0b452aeb84111f11e2798e5);
        run_block("fips_fwd", fips_in, 1'b0);
        // check the model as well as the DUT against the published result
        chk("fips_fwd_const", model(fips_in, 1'b0), fips_out);
        run_block("zero_fwd", 128'd0, 1'b0);
        chk("zero_fwd_const", out_state, {16{8'h63}});

`ifdef AES_INV_CIPHER_EN
        run_block("inv_63", {16{8'h63}}, 1'b1);
        chk("inv_63_const", out_state, 128'd0);
        run_block("fips_inv", fips_out, 1'b1);
        chk("fips_inv_const", out_state, fips_in);
`endif

        // random blocks; in_dec randomized (ignored unless the inverse is built)
        for (int i = 0; i < 8; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            run_block("random", rnd, 1'($urandom_range(1)));
        end

        // backpressure: hold DONE for 10 cycles while a new block waits
        rnd  = {$urandom, $urandom, $urandom, $urandom};
        pend = {$urandom, $urandom, $urandom, $urandom};
        accept_block(rnd, 1'b0);
        wait_done("bp_latency");
        chk("bp_result", out_state, model(rnd, 1'b0));
        snap     = out_state;
        in_state = pend;
        in_dec   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_out_valid", 128'(out_valid), 128'(1'b1));
            chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
            chk("bp_stable", out_state, snap);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("bp_release_idle", 128'({in_ready, out_valid}), 128'(2'b10));
        tick;
        in_valid = 1'b0;
        chk("bp_pending_accepted", 128'(in_ready), 128'(1'b0));
        wait_done("bp_pending_latency");
        chk("bp_pending_result", out_state, model(pend, 1'b0));
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // back-to-back with in_valid and out_ready held high
        blk_a = {$urandom, $urandom, $urandom, $urandom};
        blk_b = {$urandom, $urandom, $urandom, $urandom};
        acc = 0;
        outs = 0;
        in_state  = blk_a;
        in_dec    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && !(acc == 2 && outs == 2); cyc++) begin
            if (in_ready && in_valid && acc < 2) begin
                acc_t[acc] = cyc;
                acc++;
            end
            if (out_valid && out_ready && outs < 2) begin
                got[outs] = out_state;
                outs++;
            end
            tick;
            if (acc == 1) in_state = blk_b;
            if (acc == 2) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_accepts", 128'(acc), 128'(2));
        chk("b2b_outputs", 128'(outs), 128'(2));
        chk("b2b_interval", 128'(acc_t[1] - acc_t[0]), 128'(6));
        chk("b2b_first", got[0], model(blk_a, 1'b0));
        chk("b2b_second", got[1], model(blk_b, 1'b0));
        tick;

        // reset after column 2 has been processed
        rnd = {$urandom, $urandom, $urandom, $urandom};
        accept_block(rnd, 1'b0);
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("midrst_out_state", out_state, 128'd0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("midrst_no_valid", 128'(out_valid), 128'(1'b0));
        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_block("after_reset", rnd, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
